// File: rtl/bcd_field_updater_if.sv
// bcd_field_updater_if: field read, request, and register-write signals of the BCD field-edit engine.
// final is a reserved word, so the end-of-pass strobe is carried as final_o.
interface bcd_field_updater_if #(
    parameter int NUM_FIELDS = 9,
    parameter int IDXW       = 4
);
    logic                  iniciar;
    logic [7:0]            dato;
    logic [NUM_FIELDS-1:0] up_req;
    logic [NUM_FIELDS-1:0] down_req;
    logic                  fin;
    logic [IDXW-1:0]       field_sel;
    logic [NUM_FIELDS-1:0] clr_req;
    logic [7:0]            dir_out;
    logic [7:0]            dato_out;
    logic                  escribe;
    logic                  busy;
    logic                  final_o;
    logic                  bcd_err;

    modport slave (
        input  iniciar, dato, up_req, down_req, fin,
        output field_sel, clr_req, dir_out, dato_out, escribe, busy, final_o, bcd_err
    );

    modport master (
        output iniciar, dato, up_req, down_req, fin,
        input  field_sel, clr_req, dir_out, dato_out, escribe, busy, final_o, bcd_err
    );
endinterface

// File: rtl/bcd_field_updater.sv
// bcd_field_updater: scans two-digit BCD fields, applies pending up/down edits with per-field
// bounds (wrap or saturate), and writes each edited field to its register address.
module bcd_field_updater #(
    parameter int                        NUM_FIELDS = 9,
    parameter int                        IDXW       = 4,
    parameter logic [NUM_FIELDS*8-1:0]   MAX_VALS   = {8'h59, 8'h59, 8'h23, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59},
    parameter logic [NUM_FIELDS*8-1:0]   MIN_VALS   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00},
    parameter logic [NUM_FIELDS*8-1:0]   ADDR_VALS  = {8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21},
    parameter bit                        WRAP_EN    = 1'b1
) (
    input logic                clk,
    input logic                reset,
    bcd_field_updater_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEL, READ, CALC, WRITE, NEXT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      cur_q, cur_d;
    logic [7:0]      res_q, res_d;
    logic            err_q, err_d;
    logic [7:0]      mn, mx, inc, dec;
    logic [3:0]      hi, lo;
    logic            up, dn, bad;

    always_comb begin
        mn    = MIN_VALS[idx_q*8 +: 8];
        mx    = MAX_VALS[idx_q*8 +: 8];
        up    = bus.up_req[idx_q];
        dn    = bus.down_req[idx_q];
        hi    = cur_q[7:4];
        lo    = cur_q[3:0];
        bad   = (hi > 4'd9) || (lo > 4'd9) || (cur_q < mn) || (cur_q > mx);
        inc   = (lo == 4'd9) ? {hi + 4'd1, 4'd0} : {hi, lo + 4'd1};
        dec   = (lo == 4'd0) ? {hi - 4'd1, 4'd9} : {hi, lo - 4'd1};
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.iniciar) begin
                state_d = SEL;
                idx_d   = '0;
                err_d   = 1'b0;
            end
            SEL:  state_d = READ;
            READ: begin
                cur_d   = bus.dato;
                state_d = CALC;
            end
            CALC: begin
                // An out-of-range value is forced back to the field minimum regardless of requests
                if (bad) begin
                    res_d   = mn;
                    err_d   = 1'b1;
                    state_d = WRITE;
                end else if (up && !dn) begin
                    res_d   = (cur_q == mx) ? (WRAP_EN ? mn : mx) : inc;
                    state_d = WRITE;
                end else if (dn && !up) begin
                    res_d   = (cur_q == mn) ? (WRAP_EN ? mx : mn) : dec;
                    state_d = WRITE;
                end else begin
                    state_d = NEXT;
                end
            end
            WRITE: if (bus.fin) state_d = NEXT;
            NEXT: begin
                state_d = (idx_q == IDXW'(NUM_FIELDS - 1)) ? DONE : SEL;
                idx_d   = (idx_q == IDXW'(NUM_FIELDS - 1)) ? '0 : idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.field_sel = idx_q;
    assign bus.escribe   = (state_q == WRITE);
    assign bus.dir_out   = (state_q == WRITE) ? ADDR_VALS[idx_q*8 +: 8] : 8'h00;
    assign bus.dato_out  = (state_q == WRITE) ? res_q : 8'h00;
    assign bus.clr_req   = (state_q == NEXT) ? (NUM_FIELDS'(1) << idx_q) : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.final_o   = (state_q == DONE);
    assign bus.bcd_err   = err_q;
endmodule

// File: tb/tb_bcd_field_updater.sv
// tb_bcd_field_updater: directed and random passes on a wrapping and a saturating instance,
// checked against an integer-arithmetic model of the field edit rules.
module tb_bcd_field_updater;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [7:0] dato = 8'h00;
    logic [8:0] up_req = '0;
    logic [8:0] down_req = '0;
    logic       fin = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    logic [7:0] mx_t[9] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h23, 8'h59, 8'h59};
    logic [7:0] mn_t[9] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ad_t[9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] vals[9];

    bcd_field_updater_if #(.NUM_FIELDS(9), .IDXW(4)) iw ();
    bcd_field_updater_if #(.NUM_FIELDS(9), .IDXW(4)) is ();

    assign iw.iniciar  = iniciar;
    assign iw.dato     = dato;
    assign iw.up_req   = up_req;
    assign iw.down_req = down_req;
    assign iw.fin      = fin;
    assign is.iniciar  = iniciar;
    assign is.dato     = dato;
    assign is.up_req   = up_req;
    assign is.down_req = down_req;
    assign is.fin      = fin;

    bcd_field_updater u_wrap (.clk(clk), .reset(reset), .bus(iw.slave));
    bcd_field_updater #(.WRAP_EN(1'b0)) u_sat (.clk(clk), .reset(reset), .bus(is.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    task automatic ref_field(input int f, input logic [7:0] b, input bit u, input bit d, input bit w,
                             output bit wr, output bit er, output logic [7:0] res);
        int v, lo, hi;
        v  = b2i(b);
        lo = b2i(mn_t[f]);
        hi = b2i(mx_t[f]);
        wr = 1'b1;
        er = 1'b0;
        res = 8'h00;
        if (b[7:4] > 9 || b[3:0] > 9 || v < lo || v > hi) begin
            er  = 1'b1;
            res = mn_t[f];
        end else if (u && !d) res = i2b(v == hi ? (w ? lo : hi) : v + 1);
        else if (d && !u) res = i2b(v == lo ? (w ? hi : lo) : v - 1);
        else wr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_escribe"}, {iw.escribe, is.escribe}, 0);
        chk({tag, "_busy"}, {iw.busy, is.busy}, 0);
        chk({tag, "_final"}, {iw.final_o, is.final_o}, 0);
        chk({tag, "_err"}, {iw.bcd_err, is.bcd_err}, 0);
        chk({tag, "_dir"}, {iw.dir_out, is.dir_out}, 0);
        chk({tag, "_dato"}, {iw.dato_out, is.dato_out}, 0);
        chk({tag, "_clr"}, {iw.clr_req, is.clr_req}, 0);
        chk({tag, "_sel"}, {iw.field_sel, is.field_sel}, 0);
    endtask

    task automatic defaults();
        for (int f = 0; f < 9; f++) vals[f] = mn_t[f];
        up_req   = '0;
        down_req = '0;
    endtask

    task automatic run_pass(input string tag, input int dly);
        bit         wr[9];
        bit         e1, er, dummy;
        logic [7:0] rw[9], rs[9], hd, hv, hs;
        int         exp_fin, exp_wr, nw, wq, nxt, held, cyc, f;
        bit         done;
        er = 1'b0;
        exp_fin = 1;
        exp_wr = 0;
        for (int i = 0; i < 9; i++) begin
            ref_field(i, vals[i], up_req[i], down_req[i], 1'b1, wr[i], e1, rw[i]);
            ref_field(i, vals[i], up_req[i], down_req[i], 1'b0, dummy, e1, rs[i]);
            er |= e1;
            exp_fin += 4 + (wr[i] ? dly : 0);
            exp_wr += wr[i] ? 1 : 0;
        end
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        chk({tag, "_err_cleared"}, {iw.bcd_err, is.bcd_err}, 0);
        cyc = 1; nw = 0; wq = 0; nxt = 0; held = 0; done = 1'b0;
        hd = 0; hv = 0; hs = 0;
        while (!done && cyc < 600) begin
            dato = vals[iw.field_sel];
            chk({tag, "_busy"}, {iw.busy, is.busy}, 2'b11);
            if (iw.escribe) begin
                held++;
                if (held == 1) begin
                    f = wq;
                    while (f < 9 && !wr[f]) f++;
                    chk({tag, "_write_expected"}, f < 9, 1);
                    if (f < 9) begin
                        chk({tag, "_write_field"}, f, nxt);
                        chk({tag, "_dir"}, iw.dir_out, ad_t[f]);
                        chk({tag, "_dato_wrap"}, iw.dato_out, rw[f]);
                        chk({tag, "_sat_escribe"}, is.escribe, 1);
                        chk({tag, "_sat_dir"}, is.dir_out, ad_t[f]);
                        chk({tag, "_dato_sat"}, is.dato_out, rs[f]);
                        wq = f + 1;
                    end
                    hd = iw.dir_out; hv = iw.dato_out; hs = is.dato_out;
                    nw++;
                end else begin
                    chk({tag, "_hold"}, {iw.escribe, iw.dir_out, iw.dato_out, is.dato_out}, {1'b1, hd, hv, hs});
                end
                fin = (held == dly);
            end else begin
                held = 0;
                fin = 1'b0;
            end
            if (|iw.clr_req) begin
                chk({tag, "_clr"}, {iw.clr_req, is.clr_req}, {9'(1) << nxt, 9'(1) << nxt});
                nxt++;
            end
            if (iw.final_o) begin
                chk({tag, "_final_cycle"}, cyc, exp_fin);
                chk({tag, "_final_sat"}, is.final_o, 1);
                chk({tag, "_fields_cleared"}, nxt, 9);
                chk({tag, "_write_count"}, nw, exp_wr);
                done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        fin = 1'b0;
        chk({tag, "_timeout"}, done, 1);
        chk({tag, "_idle"}, {iw.busy, is.busy, iw.final_o, iw.escribe}, 0);
        chk({tag, "_bcd_err"}, {iw.bcd_err, is.bcd_err}, {er, er});
    endtask

    initial begin
        defaults();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_pass("all_skip", 1);

        defaults();
        vals[0] = 8'h09; up_req[0] = 1'b1;
        run_pass("carry", 1);

        defaults();
        vals[3] = 8'h31; up_req[3] = 1'b1;
        vals[4] = 8'h01; down_req[4] = 1'b1;
        vals[5] = 8'h00; down_req[5] = 1'b1;
        vals[2] = 8'h23; up_req[2] = 1'b1;
        vals[0] = 8'h00; down_req[0] = 1'b1;
        run_pass("bounds", 5);

        defaults();
        vals[1] = 8'h5A; up_req[1] = 1'b1;
        up_req[6] = 1'b1; down_req[6] = 1'b1;
        run_pass("invalid", 2);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", {iw.bcd_err, is.bcd_err}, 2'b11);

        defaults();
        up_req[0] = 1'b1;
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        for (int i = 0; i < 40 && !iw.escribe; i++) begin
            dato = vals[iw.field_sel];
            @(posedge clk); #1;
        end
        chk("reset_wait_write", iw.escribe, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_zero("mid_reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stay_idle", {iw.busy, is.busy}, 0);
        run_pass("restart", 3);

        for (int p = 0; p < 20; p++) begin
            for (int f = 0; f < 9; f++) begin
                int r, lo, hi;
                lo = b2i(mn_t[f]);
                hi = b2i(mx_t[f]);
                r = $urandom_range(7);
                vals[f] = (r == 0) ? 8'($urandom) : (r == 1) ? mn_t[f] : (r == 2) ? mx_t[f]
                        : i2b(lo + int'($urandom_range(hi - lo)));
                up_req[f]   = ($urandom_range(2) == 0);
                down_req[f] = ($urandom_range(2) == 0);
            end
            run_pass($sformatf("rand%0d", p), int'($urandom_range(4, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
